// File: rtl/fbuf_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin requester grants plus a full-buffer fill engine,
// both gated to the vertical-blanking window when BLANK_ONLY is set.
module fbuf_write_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_W     = 17,
   parameter int unsigned DATA_W     = 12,
   parameter int unsigned FBUF_DEPTH = 32400,
   parameter bit          BLANK_ONLY = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      eof,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      clear_start,
   input  logic [DATA_W-1:0]         clear_color,
   output logic                      clear_busy,
   output logic                      bram_we,
   output logic [ADDR_W-1:0]         bram_addr,
   output logic [DATA_W-1:0]         bram_din,
   output logic                      err_oob
);

   localparam int unsigned       GNT_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FBUF_DEPTH - 1);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e              state_q, state_d;
   logic [GNT_W-1:0]    last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
   logic [DATA_W-1:0]   color_q, color_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                oob_q, oob_d;

   logic                window;
   logic                hs;
   logic [GNT_W-1:0]    gnt_idx;
   logic [ADDR_W-1:0]   gnt_addr;
   logic [DATA_W-1:0]   gnt_data;
   int unsigned         cand;

   assign window = !BLANK_ONLY || eof;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         last_grant_q <= GNT_W'(NUM_REQ - 1);
         fill_cnt_q   <= '0;
         color_q      <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         din_q        <= '0;
         oob_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         fill_cnt_q   <= fill_cnt_d;
         color_q      <= color_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         oob_q        <= oob_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (clear_start) state_d = StClear;
         StClear: if (window && fill_cnt_q == LAST_ADDR) state_d = StIdle;
      endcase
   end

   // Datapath next values: requester writes in IDLE, fill writes in CLEAR
   always_comb begin
      last_grant_d = last_grant_q;
      fill_cnt_d   = fill_cnt_q;
      color_d      = color_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      din_d        = din_q;
      oob_d        = oob_q;
      unique case (state_q)
         StIdle: begin
            if (hs) begin
               last_grant_d = gnt_idx;
               // Out-of-range requests are consumed but never reach the BRAM
               if (gnt_addr > LAST_ADDR) begin
                  oob_d = 1'b1;
               end else begin
                  we_d   = 1'b1;
                  addr_d = gnt_addr;
                  din_d  = gnt_data;
               end
            end
            if (clear_start) begin
               color_d    = clear_color;
               fill_cnt_d = '0;
            end
         end
         StClear: begin
            if (window) begin
               we_d   = 1'b1;
               addr_d = fill_cnt_q;
               din_d  = color_q;
               if (fill_cnt_q != LAST_ADDR) fill_cnt_d = fill_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // Outputs: round-robin ready search starting after the last grant
   always_comb begin
      req_ready = '0;
      hs        = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      if (!rst && state_q == StIdle && window) begin
         for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(last_grant_q) + i) % NUM_REQ;
            if (!hs && req_valid[GNT_W'(cand)]) begin
               hs      = 1'b1;
               gnt_idx = GNT_W'(cand);
            end
         end
         if (hs) req_ready[gnt_idx] = 1'b1;
      end
   end

   assign gnt_addr   = req_addr[gnt_idx*ADDR_W +: ADDR_W];
   assign gnt_data   = req_data[gnt_idx*DATA_W +: DATA_W];
   assign clear_busy = (state_q == StClear);
   assign bram_we    = we_q;
   assign bram_addr  = addr_q;
   assign bram_din   = din_q;
   assign err_oob    = oob_q;

endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// Scoreboard bench for fbuf_write_arbiter: stimulus pushes expected BRAM writes, a monitor on
// the falling edge pops and compares every write the DUT issues.
module tb_fbuf_write_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 17;
   localparam int DATA_W  = 12;
   localparam int DEPTH   = 32400;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      eof;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      clear_start;
   logic [DATA_W-1:0]         clear_color;
   logic                      clear_busy;
   logic                      bram_we;
   logic [ADDR_W-1:0]         bram_addr;
   logic [DATA_W-1:0]         bram_din;
   logic                      err_oob;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;

   fbuf_write_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .eof         (eof),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .clear_start (clear_start),
      .clear_color (clear_color),
      .clear_busy  (clear_busy),
      .bram_we     (bram_we),
      .bram_addr   (bram_addr),
      .bram_din    (bram_din),
      .err_oob     (err_oob)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int a, input int d);
      wr_t e;
      e.addr = ADDR_W'(a);
      e.data = DATA_W'(d);
      exp_q.push_back(e);
   endtask

   task automatic set_req(input int i, input int a, input int d);
      req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
      req_data[i*DATA_W +: DATA_W] = DATA_W'(d);
   endtask

   // Check combinational ready for the current inputs, then advance one clock
   task automatic cycle(input string name, input logic [3:0] exp_ready);
      #1;
      check(name, 32'(req_ready), 32'(exp_ready));
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (bram_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %0h, expected no write",
                     bram_addr, bram_din);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", 32'(bram_addr), 32'(mon_e.addr));
            check("write_data", 32'(bram_din), 32'(mon_e.data));
         end
      end
   end

   initial begin
      int k;
      int c;
      rst         = 1'b1;
      eof         = 1'b1;
      req_valid   = '1;
      req_addr    = '0;
      req_data    = '0;
      clear_start = 1'b0;
      clear_color = '0;
      @(posedge clk);
      #1;
      cycle("reset_ready", 4'b0000);
      cycle("reset_ready", 4'b0000);
      check("reset_we", 32'(bram_we), 0);
      check("reset_addr", 32'(bram_addr), 0);
      check("reset_din", 32'(bram_din), 0);
      check("reset_busy", 32'(clear_busy), 0);
      check("reset_oob", 32'(err_oob), 0);

      // Round robin with all requesters active, starting at 0
      rst       = 1'b0;
      req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 10 + i, 'h100 + i);
      req_valid = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         push(10 + j % 4, 'h100 + j % 4);
         cycle("rr_ready", 4'(1 << (j % 4)));
      end
      // Sparse pattern after last grant 0: 1, 3, 1
      req_valid = 4'b1010;
      push(11, 'h101);
      cycle("rr_sparse_ready", 4'b0010);
      push(13, 'h103);
      cycle("rr_sparse_ready", 4'b1000);
      push(11, 'h101);
      cycle("rr_sparse_ready", 4'b0010);
      req_valid = '0;
      cycle("idle_ready", 4'b0000);

      // Blanking gate
      eof = 1'b0;
      set_req(2, 100, 'h5A5);
      req_valid = 4'b0100;
      for (int j = 0; j < 3; j++) cycle("blank_closed_ready", 4'b0000);
      eof = 1'b1;
      push(100, 'h5A5);
      cycle("blank_open_ready", 4'b0100);
      req_valid = '0;
      cycle("idle_ready", 4'b0000);

      // Out-of-range address then the last legal address
      check("oob_clear_before", 32'(err_oob), 0);
      set_req(0, DEPTH, 'h777);
      req_valid = 4'b0001;
      cycle("oob_ready", 4'b0001);
      req_valid = '0;
      cycle("idle_ready", 4'b0000);
      check("oob_set", 32'(err_oob), 1);
      set_req(0, DEPTH - 1, 'h321);
      req_valid = 4'b0001;
      push(DEPTH - 1, 'h321);
      cycle("last_addr_ready", 4'b0001);
      req_valid = '0;
      for (int j = 0; j < 3; j++) cycle("idle_ready", 4'b0000);
      check("oob_sticky", 32'(err_oob), 1);

      // Clear accepted alongside a handshake, then a full fill with a stray clear_start
      set_req(1, 7, 'h123);
      req_valid   = 4'b0010;
      clear_start = 1'b1;
      clear_color = 12'hABC;
      push(7, 'h123);
      cycle("clear_hs_ready", 4'b0010);
      clear_color = '0;
      for (int j = 0; j < DEPTH; j++) begin
         clear_start = (j == 1000);
         clear_color = (j == 1000) ? 12'h111 : 12'h000;
         push(j, 'hABC);
         checks++;
         if (clear_busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_busy at addr %0d: got %b, expected 1", j, clear_busy);
         end
         cycle("fill_ready", 4'b0000);
      end
      clear_start = 1'b0;
      check("busy_fall", 32'(clear_busy), 0);
      push(7, 'h123);
      cycle("post_fill_ready", 4'b0010);
      req_valid = '0;

      // Paused fill (10 open, 5 closed), reset at address 500
      clear_color = 12'h3C3;
      clear_start = 1'b1;
      cycle("pfill_start_ready", 4'b0000);
      clear_start = 1'b0;
      k = 0;
      c = 0;
      while (k < 500) begin
         eof = ((c % 15) < 10);
         if (eof) begin
            push(k, 'h3C3);
            k++;
         end
         cycle("pfill_ready", 4'b0000);
         c++;
      end
      eof = 1'b1;
      rst = 1'b1;
      cycle("rst_fill_ready", 4'b0000);
      rst = 1'b0;
      check("rst_fill_we", 32'(bram_we), 0);
      check("rst_fill_addr", 32'(bram_addr), 0);
      check("rst_fill_din", 32'(bram_din), 0);
      check("rst_fill_busy", 32'(clear_busy), 0);
      check("rst_fill_oob", 32'(err_oob), 0);
      cycle("post_rst_ready", 4'b0000);

      // Restarted fill begins at address 0
      clear_color = 12'h0F0;
      clear_start = 1'b1;
      cycle("restart_ready", 4'b0000);
      clear_start = 1'b0;
      for (int j = 0; j < 20; j++) begin
         push(j, 'h0F0);
         cycle("restart_fill_ready", 4'b0000);
      end
      rst = 1'b1;
      cycle("final_rst_ready", 4'b0000);
      rst = 1'b0;
      cycle("idle_ready", 4'b0000);
      cycle("idle_ready", 4'b0000);
      check("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fbuf_write_arbiter.md
FBUF_WRITE_ARBITER -- requirements
Module: fbuf_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of write requesters.
REQ-002 The block SHALL have parameter ADDR_W, default 17, the framebuffer address width.
REQ-003 The block SHALL have parameter DATA_W, default 12, the pixel data width.
REQ-004 The block SHALL have parameter FBUF_DEPTH, default 32400 (240x135 cells, 1080p at 8x upscale), the number of valid addresses.
REQ-005 The block SHALL have parameter BLANK_ONLY, default 1; when 1, writes are restricted to the vertical blanking window.
REQ-006 Clocking: one clock; reset is synchronous and active-high. Ports: clk, input, 1 bit, system/pixel clock; rst, input, 1 bit, reset.
REQ-007 The block SHALL have port eof, input, 1 bit: high while the raster is in vertical blanking.
REQ-008 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester write request.
REQ-009 The block SHALL have port req_addr, input, NUM_REQ*ADDR_W bits: packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port req_data, input, NUM_REQ*DATA_W bits: packed pixel data, same slicing as req_addr.
REQ-011 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester accept.
REQ-012 The block SHALL have port clear_start, input, 1 bit: single-cycle pulse that requests a full-buffer fill.
REQ-013 The block SHALL have port clear_color, input, DATA_W bits: fill value, sampled on an accepted clear_start.
REQ-014 The block SHALL have port clear_busy, output, 1 bit: high while the fill is in progress.
REQ-015 The block SHALL have ports bram_we (1 bit), bram_addr (ADDR_W bits) and bram_din (DATA_W bits), all outputs, all registered: the framebuffer write port.
REQ-016 The block SHALL have port err_oob, output, 1 bit: sticky flag for an out-of-range request address.

Function
REQ-017 The block SHALL implement a state machine with states IDLE and CLEAR.
REQ-018 Write window: a write is permitted in a cycle when BLANK_ONLY is 0 or eof is 1.
REQ-019 Ready generation:
- In IDLE with the window open, exactly one req_ready bit SHALL be high, driven combinationally: the first requester with req_valid high, searching round-robin from (last_grant+1) mod NUM_REQ.
- In every other case, req_ready SHALL be all zeros.
REQ-020 Pointer update: on a handshake (valid and ready) by requester i, last_grant SHALL become i on the next cycle; otherwise last_grant SHALL hold.
REQ-021 Write latency:
- A handshake in cycle N SHALL produce bram_we=1 in cycle N+1, with bram_addr and bram_din equal to the accepted slices.
- bram_we SHALL be 0 in every cycle not caused by a handshake or a fill write.
REQ-022 Out-of-range address: a handshake with address >= FBUF_DEPTH SHALL still be accepted, SHALL NOT assert bram_we, and SHALL set err_oob=1 until reset.
REQ-023 Entering CLEAR: clear_start in IDLE SHALL move the FSM to CLEAR on the next cycle, latch clear_color, set clear_busy=1 and load the fill counter with 0.
REQ-024 Clear priority: in the cycle clear_start is accepted, any handshake SHALL still complete normally, because ready is already evaluated in IDLE.
REQ-025 Fill writes: in CLEAR, each cycle with the window open SHALL write the latched color to the current counter address (bram_we in the following cycle) and increment the counter.
REQ-026 Fill pause: when the window is closed in CLEAR, the counter SHALL hold and no write SHALL be issued.
REQ-027 Fill end: after the write to address FBUF_DEPTH-1 is issued, the FSM SHALL return to IDLE and clear_busy SHALL fall on the next cycle; the counter SHALL NOT wrap.
REQ-028 clear_start received while in CLEAR SHALL be ignored.
REQ-029 Width rule: the fill counter SHALL be ADDR_W bits wide, and the comparison to FBUF_DEPTH-1 SHALL be unsigned.

Reset
REQ-030 While rst=1, the block SHALL set: FSM to IDLE, bram_we=0, bram_addr=0, bram_din=0, clear_busy=0, err_oob=0, last_grant=NUM_REQ-1, fill counter=0.
REQ-031 While rst=1, req_ready SHALL be all zeros.
REQ-032 Reset asserted mid-fill SHALL abort the fill; no bram_we SHALL occur in the cycle after rst is sampled high.

Verification
REQ-033 Round-robin: eof=1, all four req_valid held high -> grants go 0,1,2,3,0 on consecutive cycles, with bram_we one cycle after each grant carrying the matching addr/data.
REQ-034 Blank gating: BLANK_ONLY=1, eof=0, req_valid[2]=1, addr 100 -> req_ready stays 0; eof rises -> req_ready[2]=1 that cycle, and bram_addr=100, bram_we=1 the next cycle.
REQ-035 Out-of-range: eof=1, req_addr[0]=32400 -> req_ready[0]=1, bram_we stays 0, err_oob=1 and stays 1 until rst.
REQ-036 Full fill: eof held 1, clear_start with clear_color=0xABC -> 32400 consecutive writes to addresses 0..32399, each with data 0xABC; clear_busy falls one cycle after the last write is issued; req_ready stays 0 throughout.
REQ-037 Paused fill: eof toggled 1 for 10 cycles, then 0 for 5 cycles, repeatedly -> writes occur only in eof=1 cycles, with no address skipped or repeated.
REQ-038 Reset mid-fill: rst pulsed at fill address 500 -> outputs return to their reset values; a new clear_start then restarts the fill at address 0.
